// File: rtl/axil_reg_pkg.sv
// rtl/axil_reg_pkg.sv - register map, response codes and FSM states of the axil_reg_ctrl command sequencer
package axil_reg_pkg;

  localparam logic [31:0] REG_RD_ADDR = 32'h0000_0000;
  localparam logic [31:0] REG_RD_DATA = 32'h0000_0004;
  localparam logic [31:0] REG_WR_ADDR = 32'h0000_0008;
  localparam logic [31:0] REG_WR_DATA = 32'h0000_000C;

  localparam int          BUSY_BIT  = 31;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_DATA, ST_WR_ADDR, ST_RD_ADDR, ST_POLL, ST_RD_DATA, ST_RESP
  } seq_state_t;

  typedef enum logic [2:0] {
    X_IDLE, X_WRITE, X_BRESP, X_RADDR, X_RDATA
  } xfer_state_t;

  // Address-register value that kicks off an access: busy bit set, byte address in the low half.
  function automatic logic [31:0] kick_word(input logic [15:0] addr);
    return {1'b1, 15'h0, addr};
  endfunction

endpackage

// File: rtl/axil_reg_cmd_seq_if.sv
// rtl/axil_reg_cmd_seq_if.sv - AXI4-Lite bus between the sequencer and axil_reg_ctrl
interface axil_reg_cmd_seq_if;

  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axil_single_xfer.sv
// rtl/axil_single_xfer.sv - single-beat AXI4-Lite write/read engine with start/done/resp handshake
module axil_single_xfer
  import axil_reg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               we,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic [3:0]         wstrb,
  output logic               done,
  output logic [1:0]         resp,
  output logic [31:0]        rdata,
  axil_reg_cmd_seq_if.master m_axil
);

  xfer_state_t state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        arvalid_q;
  logic        rready_q;

  assign m_axil.awaddr  = addr_q;
  assign m_axil.awprot  = 3'h0;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = wstrb_q;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = addr_q;
  assign m_axil.arprot  = 3'h0;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= X_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done      <= 1'b0;
      resp      <= RESP_OKAY;
      rdata     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        X_IDLE: begin
          if (start) begin
            addr_q <= addr;
            if (we) begin
              wdata_q   <= wdata;
              wstrb_q   <= wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= X_WRITE;
            end else begin
              arvalid_q <= 1'b1;
              state     <= X_RADDR;
            end
          end
        end
        X_WRITE: begin
          // AW and W retire independently; B is only opened once both have gone through.
          if (awvalid_q && m_axil.awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axil.wready)   wvalid_q  <= 1'b0;
          if ((!awvalid_q || m_axil.awready) && (!wvalid_q || m_axil.wready)) begin
            bready_q <= 1'b1;
            state    <= X_BRESP;
          end
        end
        X_BRESP: begin
          if (m_axil.bvalid) begin
            bready_q <= 1'b0;
            resp     <= m_axil.bresp;
            rdata    <= '0;
            done     <= 1'b1;
            state    <= X_IDLE;
          end
        end
        X_RADDR: begin
          if (m_axil.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= X_RDATA;
          end
        end
        X_RDATA: begin
          if (m_axil.rvalid) begin
            rready_q <= 1'b0;
            resp     <= m_axil.rresp;
            rdata    <= m_axil.rdata;
            done     <= 1'b1;
            state    <= X_IDLE;
          end
        end
        default: state <= X_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axil_reg_cmd_seq.sv
// rtl/axil_reg_cmd_seq.sv - turns write/read commands into the axil_reg_ctrl register protocol
module axil_reg_cmd_seq
  import axil_reg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h44A0_0000,
  parameter int          POLL_LIMIT = 64,
  parameter int          POLL_GAP   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [15:0]        cmd_addr,
  input  logic [31:0]        cmd_data,
  input  logic [3:0]         cmd_strb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_data,
  output logic               rsp_err,
  output logic               rsp_timeout,
  axil_reg_cmd_seq_if.master m_axil
);

  localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(POLL_GAP);

  seq_state_t  state;
  logic        write_q;
  logic [15:0] addr_q;
  logic [7:0]  gap_cnt;
  logic [15:0] poll_cnt;
  logic        poll_rd;

  logic        x_start;
  logic        x_we;
  logic [31:0] x_addr;
  logic [31:0] x_wdata;
  logic [3:0]  x_wstrb;
  logic        x_done;
  logic [1:0]  x_resp;
  logic [31:0] x_rdata;

  axil_single_xfer u_xfer (
    .clk    (clk),
    .rst    (rst),
    .start  (x_start),
    .we     (x_we),
    .addr   (x_addr),
    .wdata  (x_wdata),
    .wstrb  (x_wstrb),
    .done   (x_done),
    .resp   (x_resp),
    .rdata  (x_rdata),
    .m_axil (m_axil)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      gap_cnt     <= '0;
      poll_cnt    <= '0;
      poll_rd     <= 1'b0;
      x_start     <= 1'b0;
      x_we        <= 1'b0;
      x_addr      <= '0;
      x_wdata     <= '0;
      x_wstrb     <= '0;
    end else begin
      x_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            write_q   <= cmd_write;
            addr_q    <= cmd_addr;
            x_start   <= 1'b1;
            x_we      <= 1'b1;
            if (cmd_write) begin
              x_addr  <= BASE_ADDR + REG_WR_DATA;
              x_wdata <= cmd_data;
              x_wstrb <= cmd_strb;
              state   <= ST_WR_DATA;
            end else begin
              x_addr  <= BASE_ADDR + REG_RD_ADDR;
              x_wdata <= kick_word(cmd_addr);
              x_wstrb <= 4'hF;
              state   <= ST_RD_ADDR;
            end
          end
        end
        ST_WR_DATA: begin
          if (x_done) begin
            if (x_resp != RESP_OKAY) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              state     <= ST_RESP;
            end else begin
              x_start <= 1'b1;
              x_we    <= 1'b1;
              x_addr  <= BASE_ADDR + REG_WR_ADDR;
              x_wdata <= kick_word(addr_q);
              x_wstrb <= 4'hF;
              state   <= ST_WR_ADDR;
            end
          end
        end
        ST_WR_ADDR, ST_RD_ADDR: begin
          if (x_done) begin
            if (x_resp != RESP_OKAY) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              state     <= ST_RESP;
            end else begin
              gap_cnt  <= '0;
              poll_cnt <= '0;
              poll_rd  <= 1'b0;
              state    <= ST_POLL;
            end
          end
        end
        ST_POLL: begin
          // poll_rd separates the idle gap from an outstanding read of the address register.
          if (!poll_rd) begin
            if (gap_cnt == GAP_LAST) begin
              x_start <= 1'b1;
              x_we    <= 1'b0;
              x_addr  <= BASE_ADDR + (write_q ? REG_WR_ADDR : REG_RD_ADDR);
              poll_rd <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end else if (x_done) begin
            poll_rd <= 1'b0;
            gap_cnt <= '0;
            if (x_resp != RESP_OKAY) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              state     <= ST_RESP;
            end else if (!x_rdata[BUSY_BIT]) begin
              if (write_q) begin
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                state     <= ST_RESP;
              end else begin
                x_start <= 1'b1;
                x_we    <= 1'b0;
                x_addr  <= BASE_ADDR + REG_RD_DATA;
                state   <= ST_RD_DATA;
              end
            end else if (poll_cnt == POLL_LAST) begin
              rsp_valid   <= 1'b1;
              rsp_timeout <= 1'b1;
              rsp_data    <= '0;
              state       <= ST_RESP;
            end else begin
              poll_cnt <= poll_cnt + 16'd1;
            end
          end
        end
        ST_RD_DATA: begin
          if (x_done) begin
            rsp_valid <= 1'b1;
            rsp_err   <= (x_resp != RESP_OKAY);
            rsp_data  <= (x_resp == RESP_OKAY) ? x_rdata : 32'h0;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_data    <= '0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_cmd_seq.sv
// tb/tb_axil_reg_cmd_seq.sv - directed vector bench with a behavioural axil_reg_ctrl + RAM stub
module tb_axil_reg_cmd_seq;

  localparam logic [31:0] BASE = 32'h44A0_0000;
  localparam int BUSY_POLLS = 2;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_timeout;

  axil_reg_cmd_seq_if bus ();

  axil_reg_cmd_seq #(
    .BASE_ADDR  (BASE),
    .POLL_LIMIT (8),
    .POLL_GAP   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_strb    (cmd_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .m_axil      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stub knobs, driven only by the stimulus process
  logic force_busy  = 1'b0;
  logic err_wr_data = 1'b0;
  int   aw_delay    = 0;

  // behavioural axil_reg_ctrl in front of a word RAM
  logic [31:0] ram [256] = '{default: 32'h0};
  logic        aw_got, w_got;
  logic [31:0] aw_addr_s, w_data_s;
  logic [3:0]  w_strb_s;
  int          aw_wait;
  logic [31:0] wd_reg;
  logic [3:0]  wd_strb;
  logic [31:0] rd_reg;
  int          busy_cnt;
  int          aw_total   = 0;
  int          poll_reads = 0;
  int          bad_addr   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.awready <= 1'b0; bus.wready <= 1'b0; bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      bus.arready <= 1'b0; bus.rvalid <= 1'b0; bus.rdata  <= '0;   bus.rresp <= 2'b00;
      aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0; busy_cnt <= 0;
    end else begin
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.arready <= 1'b0;
      if (bus.wvalid && bus.wready) begin
        w_got <= 1'b1; w_data_s <= bus.wdata; w_strb_s <= bus.wstrb;
      end else if (bus.wvalid && !w_got) begin
        bus.wready <= 1'b1;
      end
      if (bus.awvalid && bus.awready) begin
        aw_got <= 1'b1; aw_addr_s <= bus.awaddr; aw_total <= aw_total + 1;
        if (bus.awaddr[31:4] != BASE[31:4]) bad_addr <= bad_addr + 1;
      end else if (bus.awvalid && !aw_got && (aw_delay == 0 || w_got)) begin
        if (aw_wait >= aw_delay) bus.awready <= 1'b1;
        else aw_wait <= aw_wait + 1;
      end
      if (aw_got && w_got && !bus.bvalid) begin
        bus.bvalid <= 1'b1;
        bus.bresp  <= 2'b00;
        case (aw_addr_s[3:0])
          4'hC: begin
            wd_reg <= w_data_s; wd_strb <= w_strb_s;
            if (err_wr_data) bus.bresp <= 2'b10;
          end
          4'h8: if (w_data_s[31]) begin
            ram[w_data_s[9:2]] <= {wd_strb[3] ? wd_reg[31:24] : ram[w_data_s[9:2]][31:24],
                                   wd_strb[2] ? wd_reg[23:16] : ram[w_data_s[9:2]][23:16],
                                   wd_strb[1] ? wd_reg[15:8]  : ram[w_data_s[9:2]][15:8],
                                   wd_strb[0] ? wd_reg[7:0]   : ram[w_data_s[9:2]][7:0]};
            busy_cnt <= BUSY_POLLS;
          end
          4'h0: begin rd_reg <= ram[w_data_s[9:2]]; busy_cnt <= BUSY_POLLS; end
          default: bus.bresp <= 2'b10;
        endcase
      end
      if (bus.bvalid && bus.bready) begin
        bus.bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0;
      end
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1'b1;
        bus.rresp  <= 2'b00;
        if (bus.araddr[31:4] != BASE[31:4]) bad_addr <= bad_addr + 1;
        if (bus.araddr[3:0] == 4'h4) begin
          bus.rdata <= rd_reg;
        end else begin
          bus.rdata  <= {(force_busy || busy_cnt != 0), 31'h0};
          poll_reads <= poll_reads + 1;
          if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        end
      end else if (bus.arvalid && !bus.rvalid) begin
        bus.arready <= 1'b1;
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input bit wr, input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int hold,
                         output logic [31:0] r_data, output logic r_err,
                         output logic r_to, output bit stable);
    int n;
    stable = 1'b1; r_data = '0; r_err = 1'b0; r_to = 1'b0;
    cmd_write = wr; cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    if (n >= 200) begin chk("cmd_accept_bound", 32'd0, 32'd1); return; end
    n = 0;
    while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin chk("rsp_bound", 32'd0, 32'd1); return; end
    r_data = rsp_data; r_err = rsp_err; r_to = rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== r_data || rsp_err !== r_err) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    bit          exp_err;
    bit          exp_to;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] r_data;
  logic        r_err, r_to;
  bit          stable;
  int          snap;
  bit          quiet;

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 16'h0200, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'h0200, 32'h0,         4'h0, 32'h1122_3344, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'h0300, 32'h5566_7788, 4'h3, 32'h0000_0000, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 16'h0300, 32'h0,         4'h0, 32'h0000_7788, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h0204, 32'hA5A5_A5A5, 4'hC, 32'h0000_0000, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'h0204, 32'h0,         4'h0, 32'hA5A5_0000, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 16'h0200, 32'h0000_00EE, 4'h1, 32'h0000_0000, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 16'h0200, 32'h0,         4'h0, 32'h1122_33EE, 1'b0, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_data = '0; cmd_strb = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {29'h0, bus.awvalid, bus.wvalid, bus.bready}, 32'h0);
    chk("reset_rd",   {30'h0, bus.arvalid, bus.rready}, 32'h0);
    chk("reset_cmd_rsp", {28'h0, cmd_ready, rsp_valid, rsp_err, rsp_timeout}, 32'h0);
    chk("reset_addr_data", bus.awaddr | bus.wdata | rsp_data, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_cmd_ready", {31'h0, cmd_ready}, 32'h1);

    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, 0, r_data, r_err, r_to, stable);
      chk($sformatf("vec%0d_data", i), r_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), {31'h0, r_err}, {31'h0, vecs[i].exp_err});
      chk($sformatf("vec%0d_timeout", i), {31'h0, r_to}, {31'h0, vecs[i].exp_to});
    end

    // busy bit never clears: exactly POLL_LIMIT polls then timeout
    force_busy = 1'b1;
    snap = poll_reads;
    run_cmd(1'b0, 16'h0200, 32'h0, 4'h0, 0, r_data, r_err, r_to, stable);
    chk("busy_poll_count", poll_reads - snap, 32'd8);
    chk("busy_timeout", {31'h0, r_to}, 32'h1);
    chk("busy_data", r_data, 32'h0);
    chk("busy_err", {31'h0, r_err}, 32'h0);
    force_busy = 1'b0;

    // error on the data-register write skips the address-register write
    err_wr_data = 1'b1;
    snap = aw_total;
    run_cmd(1'b1, 16'h0240, 32'hCAFE_F00D, 4'hF, 0, r_data, r_err, r_to, stable);
    chk("err_aw_count", aw_total - snap, 32'd1);
    chk("err_flag", {31'h0, r_err}, 32'h1);
    chk("err_data", r_data, 32'h0);
    err_wr_data = 1'b0;
    repeat (2) @(negedge clk);
    chk("err_back_idle", {31'h0, cmd_ready}, 32'h1);

    // awready lags wready, response back-pressured
    aw_delay = 3;
    run_cmd(1'b1, 16'h0280, 32'hDEAD_BEEF, 4'hF, 5, r_data, r_err, r_to, stable);
    chk("slow_wr_stable", {31'h0, stable}, 32'h1);
    run_cmd(1'b0, 16'h0280, 32'h0, 4'h0, 5, r_data, r_err, r_to, stable);
    chk("slow_rd_data", r_data, 32'hDEAD_BEEF);
    chk("slow_rd_stable", {31'h0, stable}, 32'h1);
    chk("slow_rsp_dropped", {31'h0, rsp_valid}, 32'h0);
    aw_delay = 0;

    // asynchronous reset while polling
    force_busy = 1'b1;
    cmd_write = 1'b0; cmd_addr = 16'h0200; cmd_valid = 1'b1;
    snap = 0;
    while (!cmd_ready && snap < 200) begin @(negedge clk); snap++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valids", {27'h0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 32'h0);
    chk("async_rst_rsp", {30'h0, rsp_valid, cmd_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    force_busy = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) quiet = 1'b0;
    end
    chk("post_rst_no_rsp", {31'h0, quiet}, 32'h1);
    run_cmd(1'b0, 16'h0200, 32'h0, 4'h0, 0, r_data, r_err, r_to, stable);
    chk("post_rst_rd_data", r_data, 32'h1122_33EE);
    chk("post_rst_rd_flags", {30'h0, r_err, r_to}, 32'h0);
    chk("bus_addr_range", bad_addr, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
